array_ram: RTL and testbench

Single-port synchronous memory of 2^A words × N bits with a valid/ready request handshake. It backs `Array`-typed interfaces in generated stream/array logic, such as the stream-to-array reader. A client drives address, write enable and write data with `valid`; the block answers each accepted request with a one-cycle `ready` pulse, carrying read data on `do`.

---
 rtl/array_ram.sv | 87 ++++++++
 tb/tb_array_ram.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/array_ram.sv
// -----------------------------------------------------------------------------
// array_ram
//
// Single-port synchronous memory of 2^A words x N bits behind a valid/ready
// request handshake. Each accepted request is answered by exactly one
// registered ready pulse. The pulse carries the read data, or the written
// data for a write (write-through), on do_o.
//
// Ports
//   clk_i    in  1  clock, all state changes on the rising edge
//   rst_i    in  1  asynchronous, active-high reset (clears ready_o and do_o)
//   addr_i   in  A  word address of the request
//   we_i     in  1  1 = write request, 0 = read request
//   di_i     in  N  write data, ignored for reads
//   valid_i  in  1  request present on addr_i / we_i / di_i
//   do_o     out N  read data or written data; holds between requests
//   ready_o  out 1  one-cycle acknowledgement of an accepted request
// -----------------------------------------------------------------------------
module array_ram #(
    parameter int N = 8,
    parameter int A = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [A-1:0] addr_i,
    input  logic         we_i,
    input  logic [N-1:0] di_i,
    input  logic         valid_i,
    output logic [N-1:0] do_o,
    output logic         ready_o
);

    localparam int DEPTH = 1 << A;

    // Storage is deliberately not reset: contents survive reset and are
    // undefined until written.
    logic [N-1:0] mem_q [DEPTH];

    logic         ready_q;
    logic         ready_d;
    logic [N-1:0] do_q;
    logic [N-1:0] do_d;
    logic         accept_s;
    logic [N-1:0] rd_word_s;

    // Request acceptance and next-state selection for the response registers.
    always_comb begin
        // A request is not taken while its acknowledge is being shown, so a
        // client that keeps valid high through ready is served only once.
        accept_s  = valid_i & ~ready_q;
        rd_word_s = mem_q[addr_i];
        ready_d   = accept_s;
        do_d      = do_q;
        if (accept_s) begin
            if (we_i) begin
                do_d = di_i;
            end else begin
                do_d = rd_word_s;
            end
        end else begin
            do_d = do_q;
        end
    end

    // Response registers: acknowledge pulse and output data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            do_q    <= {N{1'b0}};
        end else begin
            ready_q <= ready_d;
            do_q    <= do_d;
        end
    end

    // Memory array write port; a request seen while reset is high is dropped,
    // but words committed at earlier edges are kept.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept_s && we_i) begin
            mem_q[addr_i] <= di_i;
        end
    end

    assign do_o    = do_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_array_ram.sv
module tb_array_ram;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic       we;
    logic [7:0] di;
    logic       valid;
    logic [7:0] do_o;
    logic       ready_o;

    int tests_run = 0;
    int tests_failed = 0;

    array_ram #(.N(8), .A(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .we_i    (we),
        .di_i    (di),
        .valid_i (valid),
        .do_o    (do_o),
        .ready_o (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Memory as a plain array with a written-flag per word; a request is
    // served when it is presented and no acknowledge is currently showing.
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_do;
    bit         m_do_known;
    bit         m_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready    <= 1'b0;
            m_do       <= 8'h00;
            m_do_known <= 1'b1;
        end else begin
            m_ready <= valid && !m_ready;
            if (valid && !m_ready) begin
                if (we) begin
                    m_mem[addr]   <= di;
                    m_known[addr] <= 1'b1;
                    m_do          <= di;
                    m_do_known    <= 1'b1;
                end else begin
                    m_do       <= m_mem[addr];
                    m_do_known <= m_known[addr];
                end
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("model_ready", 32'(ready_o), 32'(m_ready));
            if (m_do_known) check("model_do", 32'(do_o), 32'(m_do));
        end
    end

    // Issue one request, wait (bounded) for its acknowledge, drop valid in
    // the ready cycle. Returns do_o seen in the ready cycle and edge count.
    task automatic req(input logic [7:0] a, input logic w, input logic [7:0] d,
                       output logic [7:0] rd, output int n);
        addr  = a;
        we    = w;
        di    = d;
        valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_o && n < 4);
        if (!ready_o) begin
            tests_run++;
            tests_failed++;
            $display("FAIL req_timeout: addr %0h no ready after %0d edges", a, n);
        end
        rd    = do_o;
        valid = 1'b0;
    endtask

    logic [7:0] rd;
    int         n;

    initial begin
        rst = 1'b1; valid = 1'b0; addr = 8'h00; we = 1'b0; di = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_do", 32'(do_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single write then read
        req(8'd5, 1'b1, 8'hA7, rd, n);
        check("wr5_do", 32'(rd), 32'hA7);
        check("wr5_latency", 32'(n), 32'd1);
        req(8'd5, 1'b0, 8'h00, rd, n);
        check("rd5_do", 32'(rd), 32'hA7);

        // held valid on a read of addr 3
        req(8'd3, 1'b1, 8'h11, rd, n);
        @(posedge clk);
        #1;
        addr = 8'd3; we = 1'b0; valid = 1'b1;
        check("held_ready_0", 32'(ready_o), 32'd0);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("held_ready", 32'(ready_o), 32'(i % 2));
            check("held_do", 32'(do_o), 32'h11);
        end
        valid = 1'b0;

        // boundary addresses with neighbours
        req(8'd1, 1'b1, 8'h5A, rd, n);
        req(8'd254, 1'b1, 8'hA5, rd, n);
        req(8'd0, 1'b1, 8'h01, rd, n);
        req(8'd255, 1'b1, 8'hFF, rd, n);
        req(8'd255, 1'b0, 8'h00, rd, n);
        check("rd255", 32'(rd), 32'hFF);
        req(8'd0, 1'b0, 8'h00, rd, n);
        check("rd0", 32'(rd), 32'h01);
        req(8'd1, 1'b0, 8'h00, rd, n);
        check("rd1", 32'(rd), 32'h5A);
        req(8'd254, 1'b0, 8'h00, rd, n);
        check("rd254", 32'(rd), 32'hA5);

        // sweep of 16 words
        for (int i = 0; i < 16; i++) req(8'(i + 16), 1'b1, 8'((i + 1) % 16), rd, n);
        for (int i = 0; i < 16; i++) begin
            req(8'(i + 16), 1'b0, 8'h00, rd, n);
            check("sweep_rd", 32'(rd), 32'((i + 1) % 16));
        end

        // idle stability
        req(8'd7, 1'b1, 8'h3C, rd, n);
        req(8'd7, 1'b0, 8'h00, rd, n);
        check("rd7", 32'(rd), 32'h3C);
        for (int i = 0; i < 10; i++) begin
            addr = 8'(i * 37);
            we   = 1'b1;
            di   = 8'(8'hC0 + i);
            @(posedge clk);
            #1;
            check("idle_do", 32'(do_o), 32'h3C);
            check("idle_ready", 32'(ready_o), 32'd0);
        end
        we = 1'b0;
        req(8'd5, 1'b0, 8'h00, rd, n);
        check("idle_mem5", 32'(rd), 32'hA7);
        req(8'd0, 1'b0, 8'h00, rd, n);
        check("idle_mem0", 32'(rd), 32'h01);

        // reset in the middle of a ready cycle, with a new write pending
        @(posedge clk);
        #1;
        addr = 8'd3; we = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_ready", 32'(ready_o), 32'd1);
        addr = 8'd5; we = 1'b1; di = 8'hEE;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(ready_o), 32'd0);
        check("async_rst_do", 32'(do_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b0;
        req(8'd5, 1'b0, 8'h00, rd, n);
        check("rst_kept_mem5", 32'(rd), 32'hA7);

        // release reset with a request already present
        @(posedge clk);
        #1;
        rst = 1'b1;
        addr = 8'd3; we = 1'b0; valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(ready_o), 32'd1);
        check("post_rst_do", 32'(do_o), 32'h11);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
